// File: rtl/muldiv_iter.sv
// Iterative multiply/divide unit: restoring radix-2 divide and shift-add multiply, one bit per cycle.
// Multiply datapath is present only when MULDIV_MUL_EN is defined; otherwise multiply ops return zero.
module muldiv_iter #(
  parameter int WIDTH = 32
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [1:0]       op,
  input  logic             cancel,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic             busy,
  output logic             done,
  output logic             stall,
  output logic [WIDTH-1:0] hi,
  output logic [WIDTH-1:0] lo,
  output logic [1:0]       dbgState
);

  // Handshake: start (with op/a/b) is taken on an edge where the unit is IDLE or DONE
  // and cancel is low; done is a one-cycle valid for hi/lo; stall holds the pipeline.
  typedef enum logic [1:0] {IDLE = 2'd0, BUSY = 2'd1, DONE = 2'd2} state_t;

  localparam int M = WIDTH - 1;
  localparam int CW = $clog2(WIDTH);
  localparam logic [CW-1:0] LAST = CW'(WIDTH - 1);

  state_t state;
  logic [CW-1:0] cnt;
  logic [WIDTH-1:0] remReg, quoReg, opnd;
  logic negLo, negHi;
  logic [WIDTH-1:0] aMag, bMag;
  logic [WIDTH:0] divShift, divDiff;
  logic [WIDTH-1:0] stepHi, stepLo, resHi, resLo;
`ifdef MULDIV_MUL_EN
  logic isMul;
  logic [WIDTH:0] mulSum;
  logic [2*WIDTH-1:0] prod;
`endif

  assign aMag = (op[0] && a[M]) ? -a : a;
  assign bMag = (op[0] && b[M]) ? -b : b;
  assign dbgState = state;
  assign stall = (state == BUSY) || ((state == IDLE || state == DONE) && start && !cancel);

  // remReg/quoReg double as {partial remainder, quotient} or {product high, product low}.
  always_comb begin
    divShift = {remReg, quoReg[M]};
    divDiff  = divShift - {1'b0, opnd};
    if (!divDiff[WIDTH]) begin
      stepHi = divDiff[M:0];
      stepLo = {quoReg[M-1:0], 1'b1};
    end else begin
      stepHi = divShift[M:0];
      stepLo = {quoReg[M-1:0], 1'b0};
    end
    resHi = negHi ? -stepHi : stepHi;
    resLo = negLo ? -stepLo : stepLo;
`ifdef MULDIV_MUL_EN
    mulSum = {1'b0, remReg} + (quoReg[0] ? {1'b0, opnd} : '0);
    prod   = '0;
    if (isMul) begin
      stepHi = mulSum[WIDTH:1];
      stepLo = {mulSum[0], quoReg[M:1]};
      prod   = negLo ? -{stepHi, stepLo} : {stepHi, stepLo};
      resHi  = prod[2*WIDTH-1:WIDTH];
      resLo  = prod[M:0];
    end
`endif
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state  <= IDLE;
      busy   <= 1'b0;
      done   <= 1'b0;
      hi     <= '0;
      lo     <= '0;
      cnt    <= '0;
      remReg <= '0;
      quoReg <= '0;
      opnd   <= '0;
      negLo  <= 1'b0;
      negHi  <= 1'b0;
`ifdef MULDIV_MUL_EN
      isMul  <= 1'b0;
`endif
    end else if (cancel) begin
      state <= IDLE;
      busy  <= 1'b0;
      done  <= 1'b0;
    end else begin
      case (state)
        BUSY: begin
          remReg <= stepHi;
          quoReg <= stepLo;
          cnt    <= cnt + 1'b1;
          if (cnt == LAST) begin
            state <= DONE;
            busy  <= 1'b0;
            done  <= 1'b1;
            hi    <= resHi;
            lo    <= resLo;
          end
        end
        default: begin
          if (start) begin
            if (!op[1] && b == '0) begin
              state <= DONE;
              busy  <= 1'b0;
              done  <= 1'b1;
              hi    <= a;
              lo    <= '1;
            end
`ifndef MULDIV_MUL_EN
            else if (op[1]) begin
              state <= DONE;
              busy  <= 1'b0;
              done  <= 1'b1;
              hi    <= '0;
              lo    <= '0;
            end
`endif
            else begin
              state  <= BUSY;
              busy   <= 1'b1;
              done   <= 1'b0;
              cnt    <= '0;
              remReg <= '0;
              negLo  <= op[0] & (a[M] ^ b[M]);
              negHi  <= op[0] & a[M];
`ifdef MULDIV_MUL_EN
              isMul  <= op[1];
              if (op[1]) begin
                quoReg <= bMag;
                opnd   <= aMag;
              end else begin
                quoReg <= aMag;
                opnd   <= bMag;
              end
`else
              quoReg <= aMag;
              opnd   <= bMag;
`endif
            end
          end else begin
            state <= IDLE;
            done  <= 1'b0;
          end
        end
      endcase
    end
  end

endmodule

// File: tb/tb_muldiv_iter.sv
// Self-checking bench for muldiv_iter: cycle-level arithmetic model plus directed vectors.
// Expectations for multiply ops follow MULDIV_MUL_EN as defined for the build.
module tb_muldiv_iter;
  localparam int W = 32;

  logic clk = 1'b0;
  logic rst, start, cancel;
  logic [1:0] op;
  logic [W-1:0] a, b;
  logic busy, done, stall;
  logic [W-1:0] hi, lo;
  logic [1:0] dbgState;

  muldiv_iter #(.WIDTH(W)) dut (
    .clk(clk), .rst(rst), .start(start), .op(op), .cancel(cancel), .a(a), .b(b),
    .busy(busy), .done(done), .stall(stall), .hi(hi), .lo(lo), .dbgState(dbgState)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;
  bit chkEn = 1'b0;

  task automatic chk(input string name, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s at %0t: got %h expected %h", name, $time, got, exp);
    end
  endtask

  // Arithmetic reference: plain 64-bit integer math on the operands.
  function automatic void refResult(input logic [1:0] o, input logic [W-1:0] x, input logic [W-1:0] y,
                                    output logic [W-1:0] rh, output logic [W-1:0] rl, output bit imm);
    longint sa, sb, q, r, p;
    longint unsigned up;
    sa = longint'($signed(x));
    sb = longint'($signed(y));
    imm = 1'b0;
    rh = '0;
    rl = '0;
    if (!o[1]) begin
      if (y == '0) begin
        rl = '1;
        rh = x;
        imm = 1'b1;
      end else if (!o[0]) begin
        rl = x / y;
        rh = x % y;
      end else begin
        q = sa / sb;
        r = sa % sb;
        rl = q[31:0];
        rh = r[31:0];
      end
    end else begin
`ifdef MULDIV_MUL_EN
      if (o[0]) begin
        p = sa * sb;
        rh = p[63:32];
        rl = p[31:0];
      end else begin
        up = {32'b0, x} * {32'b0, y};
        rh = up[63:32];
        rl = up[31:0];
      end
`else
      imm = 1'b1;
`endif
    end
  endfunction

  // Cycle model: cycles of BUSY remaining, done flag, visible and pending results.
  int remaining = 0;
  logic mDone = 1'b0;
  logic [W-1:0] mHi = '0, mLo = '0, pHi = '0, pLo = '0, rh, rl;
  bit imm;

  always @(posedge clk) begin
    if (rst) begin
      remaining = 0;
      mDone = 1'b0;
      mHi = '0;
      mLo = '0;
    end else if (cancel) begin
      remaining = 0;
      mDone = 1'b0;
    end else if (remaining > 0) begin
      remaining--;
      if (remaining == 0) begin
        mDone = 1'b1;
        mHi = pHi;
        mLo = pLo;
      end
    end else if (start) begin
      refResult(op, a, b, rh, rl, imm);
      if (imm) begin
        mDone = 1'b1;
        mHi = rh;
        mLo = rl;
      end else begin
        remaining = W;
        pHi = rh;
        pLo = rl;
        mDone = 1'b0;
      end
    end else begin
      mDone = 1'b0;
    end
  end

  always @(negedge clk) begin
    if (chkEn) begin
      chk("cyc_busy", 64'(busy), 64'(remaining > 0));
      chk("cyc_done", 64'(done), 64'(mDone));
      chk("cyc_stall", 64'(stall), 64'((remaining > 0) || (start && !cancel)));
      chk("cyc_hi", 64'(hi), 64'(mHi));
      chk("cyc_lo", 64'(lo), 64'(mLo));
    end
  end

  task automatic issue(input logic [1:0] o, input logic [W-1:0] x, input logic [W-1:0] y);
    @(negedge clk); #1;
    op = o; a = x; b = y; start = 1'b1;
    @(negedge clk); #1;
    start = 1'b0;
  endtask

  // Counts cycles from the first cycle after acceptance up to and including the done cycle.
  task automatic waitDone(input int limit, output int cyc, output int bc);
    cyc = 1;
    bc = 0;
    forever begin
      if (busy) bc++;
      if (done || cyc >= limit) break;
      @(negedge clk); #1;
      cyc++;
    end
  endtask

  task automatic runOp(input string name, input logic [1:0] o, input logic [W-1:0] x, input logic [W-1:0] y,
                       input int expCyc, input logic [W-1:0] expHi, input logic [W-1:0] expLo);
    int cyc, bc;
    issue(o, x, y);
    waitDone(60, cyc, bc);
    chk({name, "_latency"}, 64'(cyc), 64'(expCyc));
    chk({name, "_busycycles"}, 64'(bc), 64'((expCyc == 1) ? 0 : W));
    chk({name, "_hi"}, 64'(hi), 64'(expHi));
    chk({name, "_lo"}, 64'(lo), 64'(expLo));
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int cyc, bc;
    bit sawDone;
    rst = 1'b1; start = 1'b0; cancel = 1'b0; op = 2'b00; a = '0; b = '0;
    @(posedge clk); #1;
    chkEn = 1'b1;
    @(negedge clk); #1;
    chk("reset_busy", 64'(busy), 64'(0));
    chk("reset_done", 64'(done), 64'(0));
    chk("reset_hi", 64'(hi), 64'(0));
    chk("reset_lo", 64'(lo), 64'(0));
    rst = 1'b0;

    runOp("divu_100_7", 2'b00, 32'd100, 32'd7, 33, 32'd2, 32'd14);
    @(negedge clk); #1;
    chk("after_done_stall", 64'(stall), 64'(0));
    chk("after_done_done", 64'(done), 64'(0));

    runOp("div_m7_2", 2'b01, 32'hFFFFFFF9, 32'd2, 33, 32'hFFFFFFFF, 32'hFFFFFFFD);
    runOp("div_min_m1", 2'b01, 32'h80000000, 32'hFFFFFFFF, 33, 32'h0, 32'h80000000);
    runOp("divu_5_0", 2'b00, 32'd5, 32'd0, 1, 32'd5, 32'hFFFFFFFF);
    runOp("div_m7_0", 2'b01, 32'hFFFFFFF9, 32'd0, 1, 32'hFFFFFFF9, 32'hFFFFFFFF);
    runOp("divu_max_1", 2'b00, 32'hFFFFFFFF, 32'd1, 33, 32'h0, 32'hFFFFFFFF);
    runOp("div_7_m2", 2'b01, 32'd7, 32'hFFFFFFFE, 33, 32'd1, 32'hFFFFFFFD);
    runOp("div_m8_m3", 2'b01, 32'hFFFFFFF8, 32'hFFFFFFFD, 33, 32'hFFFFFFFE, 32'd2);
    runOp("divu_3_10", 2'b00, 32'd3, 32'd10, 33, 32'd3, 32'd0);
`ifdef MULDIV_MUL_EN
    runOp("mult_m1_3", 2'b11, 32'hFFFFFFFF, 32'd3, 33, 32'hFFFFFFFF, 32'hFFFFFFFD);
    runOp("multu_max_3", 2'b10, 32'hFFFFFFFF, 32'd3, 33, 32'd2, 32'hFFFFFFFD);
    runOp("mult_min_min", 2'b11, 32'h80000000, 32'h80000000, 33, 32'h40000000, 32'h0);
    runOp("mult_7_m2", 2'b11, 32'd7, 32'hFFFFFFFE, 33, 32'hFFFFFFFF, 32'hFFFFFFF2);
`else
    runOp("mult_off", 2'b11, 32'hFFFFFFFF, 32'd3, 1, 32'h0, 32'h0);
    runOp("multu_off", 2'b10, 32'hFFFFFFFF, 32'd3, 1, 32'h0, 32'h0);
`endif

    // Cancel in the 10th busy cycle keeps the previous result.
    runOp("pre_cancel", 2'b00, 32'd100, 32'd7, 33, 32'd2, 32'd14);
    issue(2'b00, 32'd1000, 32'd3);
    repeat (9) begin @(negedge clk); #1; end
    chk("cancel_busy_before", 64'(busy), 64'(1));
    cancel = 1'b1;
    @(negedge clk); #1;
    cancel = 1'b0;
    chk("cancel_busy_after", 64'(busy), 64'(0));
    sawDone = 1'b0;
    repeat (40) begin
      if (done) sawDone = 1'b1;
      @(negedge clk); #1;
    end
    chk("cancel_no_done", 64'(sawDone), 64'(0));
    chk("cancel_hi_kept", 64'(hi), 64'(2));
    chk("cancel_lo_kept", 64'(lo), 64'(14));

    // Start while busy is ignored.
    issue(2'b00, 32'd100, 32'd7);
    repeat (3) begin @(negedge clk); #1; end
    start = 1'b1; op = 2'b00; a = 32'd9; b = 32'd2;
    @(negedge clk); #1;
    start = 1'b0;
    waitDone(60, cyc, bc);
    chk("ignore_latency", 64'(cyc), 64'(29));
    chk("ignore_hi", 64'(hi), 64'(2));
    chk("ignore_lo", 64'(lo), 64'(14));

    // Reset in the 5th busy cycle.
    runOp("pre_reset", 2'b00, 32'd1000, 32'd3, 33, 32'd1, 32'd333);
    issue(2'b00, 32'd100, 32'd7);
    repeat (4) begin @(negedge clk); #1; end
    rst = 1'b1;
    @(negedge clk); #1;
    chk("midrst_busy", 64'(busy), 64'(0));
    chk("midrst_done", 64'(done), 64'(0));
    chk("midrst_stall", 64'(stall), 64'(0));
    chk("midrst_hi", 64'(hi), 64'(0));
    chk("midrst_lo", 64'(lo), 64'(0));
    rst = 1'b0;

    // Back-to-back start in the done cycle.
    issue(2'b00, 32'd100, 32'd7);
    waitDone(60, cyc, bc);
    chk("b2b_first_latency", 64'(cyc), 64'(33));
    start = 1'b1; op = 2'b01; a = 32'hFFFFFFF9; b = 32'd2;
    #1;
    chk("b2b_done_pulse", 64'(done), 64'(1));
    chk("b2b_stall", 64'(stall), 64'(1));
    @(negedge clk); #1;
    start = 1'b0;
    chk("b2b_busy", 64'(busy), 64'(1));
    chk("b2b_done_cleared", 64'(done), 64'(0));
    waitDone(60, cyc, bc);
    chk("b2b_second_latency", 64'(cyc), 64'(33));
    chk("b2b_hi", 64'(hi), 64'(32'hFFFFFFFF));
    chk("b2b_lo", 64'(lo), 64'(32'hFFFFFFFD));

    repeat (3) begin @(negedge clk); #1; end
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/muldiv_iter.md
MULDIV_ITER -- requirements
Module: muldiv_iter

Interface
REQ-001 SHALL have parameter WIDTH, default 32, operand/result width (even, >=4).
REQ-002 SHALL have port clk  in  1  single clock; all state on rising edge.
REQ-003 SHALL have port rst  in  1  synchronous active-high reset.
REQ-004 SHALL have port start  in  1  request new operation; sampled only in IDLE or DONE.
REQ-005 SHALL have port op  in  2  00 divu, 01 div, 10 multu, 11 mult; sampled with start.
REQ-006 SHALL have port cancel  in  1  abort (pipeline flush); any state.
REQ-007 SHALL have port a  in  WIDTH  dividend/multiplicand; sampled with start.
REQ-008 SHALL have port b  in  WIDTH  divisor/multiplier; sampled with start.
REQ-009 SHALL have port busy  out  1  high while in BUSY.
REQ-010 SHALL have port done  out  1  one-cycle pulse; hi/lo valid.
REQ-011 SHALL have port stall  out  1  combinational pipeline stall request.
REQ-012 SHALL have port hi  out  WIDTH  remainder (div) / product upper half (mul).
REQ-013 SHALL have port lo  out  WIDTH  quotient (div) / product lower half (mul).

Function
REQ-014 SHALL implement states IDLE, BUSY, DONE; IDLE/DONE + start & ~cancel -> BUSY; BUSY after WIDTH iteration cycles -> DONE; DONE without start -> IDLE.
REQ-015 SHALL, for start accepted at edge t, hold busy=1 for cycles t+1..t+WIDTH and done=1 in cycle t+WIDTH+1 only.
REQ-016 SHALL drive stall = BUSY | ((IDLE|DONE) & start & ~cancel); stall=0 in the done cycle absent a new start.
REQ-017 SHALL perform division as restoring radix-2, one quotient bit per BUSY cycle.
REQ-018 SHALL perform multiplication as shift-add, one multiplier bit per BUSY cycle, 2*WIDTH-bit product {hi,lo}.
REQ-019 SHALL, for signed ops, operate on magnitudes and negate: quotient sign = a[MSB]^b[MSB], remainder sign = a[MSB], product sign = a[MSB]^b[MSB].
REQ-020 SHALL, for signed min / -1, return lo=min (1 followed by zeros), hi=0.
REQ-021 SHALL, on divide by b=0, skip BUSY: DONE at t+1, lo=all ones, hi=a.
REQ-022 SHALL ignore start while BUSY; operands/op latched internally at acceptance.
REQ-023 SHALL update hi/lo only on entry to DONE; values hold until next DONE.
REQ-024 SHALL, on cancel, go to IDLE next edge, no done, hi/lo unchanged; cancel beats start in same cycle.
REQ-025 SHALL accept start in DONE state, pulsing done that cycle while entering BUSY for the new op.

Reset
REQ-026 SHALL, on rst at any edge (incl. mid-operation), enter IDLE; busy=0, done=0, hi=0, lo=0; rst beats start/cancel.
REQ-027 SHALL clear all internal iteration counters and partial results on rst.

Configuration
REQ-028 SHALL use macro MULDIV_MUL_EN: defined -> multiply ops per REQ-018/019.
REQ-029 SHALL, without MULDIV_MUL_EN, synthesise no multiply datapath; op[1]=1 is accepted, DONE at t+1, hi=lo=0; divide behaviour unchanged.

Verification
REQ-030 SHALL test divu a=100 b=7 (WIDTH=32) -> busy 32 cycles, done at t+33, lo=14, hi=2, stall low after done.
REQ-031 SHALL test div a=0xFFFFFFF9 (-7) b=2 -> lo=0xFFFFFFFD, hi=0xFFFFFFFF; div 0x80000000 / 0xFFFFFFFF -> lo=0x80000000, hi=0.
REQ-032 SHALL test divu a=5 b=0 -> done at t+1, lo=0xFFFFFFFF, hi=5, busy never high.
REQ-033 SHALL test (MULDIV_MUL_EN) mult 0xFFFFFFFF*3 -> hi=0xFFFFFFFF, lo=0xFFFFFFFD; multu same -> hi=2, lo=0xFFFFFFFD; without macro -> hi=lo=0 at t+1.
REQ-034 SHALL test cancel at 10th BUSY cycle -> busy=0 next cycle, no done, hi/lo retain prior result; start during BUSY -> ignored, original result returned.
REQ-035 SHALL test rst asserted at 5th BUSY cycle -> next cycle IDLE, all outputs 0; back-to-back start in DONE -> done pulse plus new op done WIDTH+1 cycles later.
